// File: rtl/md_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide controller.
package md_pkg;
  localparam int XLEN           = 32;
  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Which source feeds hi/lo when the DONE cycle commits.
  typedef enum logic [1:0] {
    RES_MUL = 2'd0,
    RES_DIV = 2'd1,
    RES_DBZ = 2'd2
  } md_res_e;
endpackage

// File: rtl/md_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle; magnitudes only.
module md_div_iter import md_pkg::*; #(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
  logic [XLEN:0]    shifted, diff;

  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign diff      = shifted - {1'b0, dvs_q};
  assign last      = (cnt == CNT_W'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (abort)         cnt <= '0;
    else if (start)         cnt <= CNT_W'(DIV_CYCLES);
    else if (cnt != '0)     cnt <= cnt - CNT_W'(1);
  end

  // Quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (cnt != '0) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide controller: stalls EX while a MUL/DIV runs, commits in DONE.
module md_ctrl import md_pkg::*; #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    logic signed [XLEN-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  md_state_e state, state_nxt;
  md_res_e   res_kind_q;
  logic      q_neg_q, r_neg_q;
  logic      accept, acc_mul, acc_div, acc_dbz, acc_mthi, acc_mtlo;
  logic      is_div, op_signed, commit;
  logic [XLEN-1:0] a_q, hi_q, lo_q, res_hi, res_lo;
  logic [XLEN-1:0] div_a_mag, div_b_mag, div_quo, div_rem;
  logic            div_last;

  logic signed [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [2*XLEN-1:0]        prod_p [MUL_CYCLES];
  logic [MUL_CYCLES-1:0]    vld_p;

  assign op_signed = (req_op == OP_MULT) || (req_op == OP_DIV);
  assign is_div    = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign accept    = (state == ST_IDLE) && req_valid && !flush && (req_op <= OP_MTLO);
  assign acc_mul   = accept && ((req_op == OP_MULT) || (req_op == OP_MULTU));
  assign acc_div   = accept && is_div && (op_b != '0);
  assign acc_dbz   = accept && is_div && (op_b == '0);
  assign acc_mthi  = accept && (req_op == OP_MTHI);
  assign acc_mtlo  = accept && (req_op == OP_MTLO);

  // Exact 64-bit product from 32-bit operands, sign- or zero-extended.
  assign mul_a    = {{XLEN{op_signed & op_a[XLEN-1]}}, op_a};
  assign mul_b    = {{XLEN{op_signed & op_b[XLEN-1]}}, op_b};
  assign mul_prod = mul_a * mul_b;

  assign div_a_mag = cond_neg(op_a, op_signed & op_a[XLEN-1]);
  assign div_b_mag = cond_neg(op_b, op_signed & op_b[XLEN-1]);

  md_div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (acc_div),
    .abort     (flush),
    .dividend  (div_a_mag),
    .divisor   (div_b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  // Stage p0 captures the product on accept; later stages hold it until DONE.
  always_ff @(posedge clk) begin
    if (acc_mul) prod_p[0] <= mul_prod;
    for (int i = 1; i < MUL_CYCLES; i++) prod_p[i] <= prod_p[i-1];
    if (acc_dbz) a_q <= op_a;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      vld_p      <= '0;
      res_kind_q <= RES_MUL;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      vld_p <= flush ? '0 : ((vld_p << 1) | MUL_CYCLES'(acc_mul));
      if (acc_mul || acc_div || acc_dbz) begin
        res_kind_q <= acc_mul ? RES_MUL : (acc_div ? RES_DIV : RES_DBZ);
        q_neg_q    <= op_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
        r_neg_q    <= op_signed & op_a[XLEN-1];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        stall = rst && req_valid && !flush && (req_op <= OP_DIVU);
        if (acc_mul)      state_nxt = ST_MUL;
        else if (acc_div) state_nxt = ST_DIV;
        else if (acc_dbz) state_nxt = ST_DONE;
      end
      ST_MUL: begin
        stall = 1'b1;
        if (flush)                        state_nxt = ST_IDLE;
        else if (vld_p[MUL_CYCLES-1])     state_nxt = ST_DONE;
      end
      ST_DIV: begin
        stall = 1'b1;
        if (flush)         state_nxt = ST_IDLE;
        else if (div_last) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Results are presented during DONE and written into hi/lo only if not flushed.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (res_kind_q)
      RES_MUL: {res_hi, res_lo} = prod_p[MUL_CYCLES-1];
      RES_DIV: begin
        res_lo = cond_neg(div_quo, q_neg_q);
        res_hi = cond_neg(div_rem, r_neg_q);
      end
      RES_DBZ: begin
        res_lo = '1;
        res_hi = a_q;
      end
      default: ;
    endcase
  end

  assign commit      = (state == ST_DONE) && !flush;
  assign done        = commit;
  assign div_by_zero = commit && (res_kind_q == RES_DBZ);
  assign hi          = commit ? res_hi : hi_q;
  assign lo          = commit ? res_lo : lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (acc_mthi) hi_q <= op_a;
      if (acc_mtlo) lo_q <= op_a;
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with a cycle-level reference model and literal result checks.
module tb_md_ctrl;
  localparam int MC = 2;
  localparam int DC = 32;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid;
  logic [2:0]  req_op;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dbz_cnt = 0;
  int last_done_cyc = -1;

  md_ctrl #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: 'left' counts cycles remaining until and including the commit cycle.
  int          left = 0;
  logic [31:0] mhi = 0, mlo = 0, rhi = 0, rlo = 0;
  logic        rdbz = 0;

  always @(negedge clk) begin : cmp
    logic e_stall, e_busy, e_done, e_dbz;
    logic [31:0] e_hi, e_lo;
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] p;
    if (!rst) begin
      left = 0; mhi = 0; mlo = 0;
      e_stall = 0; e_busy = 0; e_done = 0; e_dbz = 0; e_hi = 0; e_lo = 0;
    end else begin
      e_busy  = (left > 0);
      e_done  = (left == 1) && !flush;
      e_dbz   = e_done && rdbz;
      e_hi    = e_done ? rhi : mhi;
      e_lo    = e_done ? rlo : mlo;
      e_stall = (left > 1) || (left == 0 && req_valid && req_op <= 3 && !flush);
    end
    chk("stall", stall, e_stall);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("div_by_zero", div_by_zero, e_dbz);
    chk("hi", hi, e_hi);
    chk("lo", lo, e_lo);
    if (done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
    if (div_by_zero === 1'b1) dbz_cnt++;
    if (rst) begin
      if (left > 0) begin
        if (e_done) begin mhi = rhi; mlo = rlo; end
        left = flush ? 0 : left - 1;
      end else if (req_valid && !flush) begin
        sa = $signed(op_a); sb = $signed(op_b); ua = op_a; ub = op_b;
        case (req_op)
          3'd0: begin p = sa * sb; {rhi, rlo} = p; rdbz = 0; left = MC + 1; end
          3'd1: begin p = ua * ub; {rhi, rlo} = p; rdbz = 0; left = MC + 1; end
          3'd2, 3'd3: begin
            if (op_b == 0) begin
              rhi = op_a; rlo = 32'hFFFF_FFFF; rdbz = 1; left = 1;
            end else begin
              if (req_op == 3'd2) begin sq = sa / sb; sr = sa % sb; end
              else begin sq = longint'(ua / ub); sr = longint'(ua % ub); end
              rlo = 32'(sq); rhi = 32'(sr); rdbz = 0; left = DC + 1;
            end
          end
          3'd4: mhi = op_a;
          3'd5: mlo = op_a;
          default: ;
        endcase
      end
    end
  end

  // Present a request and hold it while stall is sampled high; returns after the releasing edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nstall, output int acc_cyc);
    logic s;
    bit   ok;
    req_valid = 1; req_op = op; op_a = a; op_b = b;
    acc_cyc = cyc; nstall = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      s = stall;
      if (s) nstall++;
      @(posedge clk); #1;
      if (!s) begin ok = 1; break; end
    end
    if (!ok) chk("issue_timeout", 32'd1, 32'd0);
    req_valid = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int ns, ac, d0, z0;
    logic [31:0] h0, l0;
    rst = 0; flush = 0; req_valid = 0; req_op = 0; op_a = 0; op_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", busy, 32'h0);
    rst = 1;
    @(posedge clk); #1;

    // Signed multiply with small negative operand
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, ns, ac);
    chk("mult_latency", last_done_cyc - ac, MC + 1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // Signed divide -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, ns, ac);
    chk("div_latency", last_done_cyc - ac, DC + 1);
    chk("div_stall_cycles", ns, 33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero
    z0 = dbz_cnt;
    issue(3'd3, 32'd100, 32'd0, ns, ac);
    chk("dbz_latency", last_done_cyc - ac, 1);
    chk("dbz_pulses", dbz_cnt - z0, 1);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);
    chk("dbz_hi", hi, 32'd100);

    // Boundary signed cases
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, ns, ac);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, ns, ac);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    issue(3'd2, 32'd7, 32'hFFFF_FFFE, ns, ac);
    chk("div_negb_lo", lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", hi, 32'd1);

    // Back-to-back: second request lands in the IDLE cycle after DONE
    issue(3'd1, 32'd5, 32'd6, ns, ac);
    chk("multu_lo", lo, 32'd30);
    issue(3'd3, 32'd45, 32'd7, ns, ac);
    chk("b2b_latency", last_done_cyc - ac, DC + 1);
    chk("divu_lo", lo, 32'd6);
    chk("divu_hi", hi, 32'd3);

    // Flush a divide ten cycles after accept
    h0 = hi; l0 = lo; d0 = done_cnt;
    req_valid = 1; req_op = 3'd2; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    chk("flush_div_busy", busy, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_div_hi", hi, h0);
    chk("flush_div_lo", lo, l0);
    chk("flush_div_nodone", done_cnt - d0, 0);

    // Flush during the DONE cycle of a multiply
    h0 = hi; l0 = lo; d0 = done_cnt;
    req_valid = 1; req_op = 3'd0; op_a = 32'd7; op_b = 32'd9;
    repeat (MC + 1) @(posedge clk);
    #1 flush = 1;
    #1 chk("flush_done_pulse", done, 32'd0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("flush_done_hi", hi, h0);
    chk("flush_done_lo", lo, l0);
    chk("flush_done_nodone", done_cnt - d0, 0);

    // MTHI under flush is not accepted; reserved op is ignored
    req_valid = 1; req_op = 3'd4; op_a = 32'hDEAD_BEEF; flush = 1;
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    chk("mthi_flushed", hi, h0);
    req_valid = 1; req_op = 3'd6; op_a = 32'h55; op_b = 32'h2;
    #1 chk("reserved_stall", stall, 32'd0);
    @(posedge clk); #1;
    req_valid = 0;
    chk("reserved_busy", busy, 32'd0);

    // MTLO then MULTU held through DONE
    issue(3'd5, 32'h0000_1234, 32'd0, ns, ac);
    chk("mtlo_lo", lo, 32'h0000_1234);
    d0 = done_cnt;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns, ac);
    repeat (3) @(posedge clk);
    #1;
    chk("multu_single_done", done_cnt - d0, 1);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    chk("multu_idle", busy, 32'd0);

    // Reset in the middle of a divide
    req_valid = 1; req_op = 3'd2; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    repeat (5) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_stall", stall, 32'd0);
    @(posedge clk); #1;
    rst = 1; req_valid = 0;
    @(posedge clk); #1;
    issue(3'd3, 32'd9, 32'd4, ns, ac);
    chk("postrst_lat", last_done_cyc - ac, DC + 1);
    chk("postrst_lo", lo, 32'd2);
    chk("postrst_hi", hi, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
